// File: rtl/spi_slave_mode_if.sv
// spi_slave_mode_if: SPI pins plus TX/RX handshake and status bundle for spi_slave_mode.
interface spi_slave_mode_if #(parameter int DW = 8);
    logic sclk, cs_n, mosi, miso, miso_oe;
    logic [DW-1:0] tx_data, rx_data;
    logic tx_valid, tx_ready, rx_valid, rx_ready;
    logic overrun, underrun, frame_err, busy;
    modport slave (
        input sclk, cs_n, mosi, tx_data, tx_valid, rx_ready,
        output miso, miso_oe, tx_ready, rx_data, rx_valid, overrun, underrun, frame_err, busy
    );
    modport master (
        output sclk, cs_n, mosi, tx_data, tx_valid, rx_ready,
        input miso, miso_oe, tx_ready, rx_data, rx_valid, overrun, underrun, frame_err, busy
    );
endinterface

// File: rtl/spi_slave_mode.sv
// spi_slave_mode: oversampled SPI slave, all CPOL/CPHA modes, ready/valid TX and RX sides.
// Define SPI_SLV_RXFIFO_EN for an RX_DEPTH-entry first-word-fall-through RX FIFO.
module spi_slave_mode #(
    parameter int DW = 8,
    parameter int CPOL = 0,
    parameter int CPHA = 0,
    parameter int LSB_FIRST = 1,
    parameter int RX_DEPTH = 4
) (
    input logic clk,
    input logic rst,
    spi_slave_mode_if.slave bus
);
    localparam int CW = $clog2(DW);
`ifdef SPI_SLV_RXFIFO_EN
    localparam int DEPTH = RX_DEPTH;
`else
    localparam int DEPTH = 1;
`endif
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    typedef enum logic {IDLE, ACTIVE} state_t;
    state_t state, state_n;
    logic [2:0] sclk_q, cs_q;
    logic [1:0] mosi_q;
    logic [CW-1:0] cnt;
    logic [DW-1:0] rx_sh, tx_sh, hold_q;
    logic hold_full, fresh, und_pend, done_q, underrun_q, frame_err_q;
    logic act, sclk_edge, lead, trail, cs_fall, cs_rise, go, sample, shift, last, ws, cap;
    assign sclk_edge = sclk_q[2] ^ sclk_q[1];
    assign lead = sclk_edge & (sclk_q[1] != 1'(CPOL));
    assign trail = sclk_edge & (sclk_q[1] == 1'(CPOL));
    assign cs_fall = cs_q[2] & ~cs_q[1];
    assign cs_rise = ~cs_q[2] & cs_q[1];
    assign act = state == ACTIVE;
    assign go = act & ~cs_rise;
    assign sample = go & (CPHA != 0 ? trail : lead);
    assign shift = go & (CPHA != 0 ? lead : trail);
    assign last = cnt == CW'(DW - 1);
    assign ws = (~act & cs_fall) | (sample & last);
    assign cap = bus.tx_valid & ~hold_full;
    // cs_n chain resets low so a select held low across reset is not taken as a new frame
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_q <= {3{1'(CPOL)}};
            cs_q <= '0;
            mosi_q <= '0;
        end else begin
            sclk_q <= {sclk_q[1:0], bus.sclk};
            cs_q <= {cs_q[1:0], bus.cs_n};
            mosi_q <= {mosi_q[0], bus.mosi};
        end
    end
    always_ff @(posedge clk) state <= rst ? IDLE : state_n;
    always_comb begin
        state_n = state;
        state_n = act ? (cs_rise ? IDLE : ACTIVE) : (cs_fall ? ACTIVE : IDLE);
    end
    // underrun is reported when the empty word actually begins clocking, not when it is loaded
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            rx_sh <= '0;
            tx_sh <= '0;
            hold_q <= '0;
            hold_full <= 1'b0;
            fresh <= 1'b0;
            und_pend <= 1'b0;
            done_q <= 1'b0;
            underrun_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            done_q <= sample & last;
            underrun_q <= go & lead & und_pend;
            frame_err_q <= act & cs_rise & (cnt != '0);
            hold_full <= cap | (hold_full & ~ws);
            if (cap) hold_q <= bus.tx_data;
            if (act & cs_rise) begin
                cnt <= '0;
                rx_sh <= '0;
                tx_sh <= '0;
                und_pend <= 1'b0;
            end else begin
                if (sample) begin
                    cnt <= last ? '0 : cnt + 1'b1;
                    rx_sh <= LSB_FIRST != 0 ? {mosi_q[1], rx_sh[DW-1:1]} : {rx_sh[DW-2:0], mosi_q[1]};
                end
                if (ws) begin
                    tx_sh <= hold_full ? hold_q : '0;
                    fresh <= 1'b1;
                    und_pend <= ~hold_full;
                end else begin
                    if (shift & (CPHA != 0 ? ~fresh : cnt != '0))
                        tx_sh <= LSB_FIRST != 0 ? tx_sh >> 1 : tx_sh << 1;
                    if (shift) fresh <= 1'b0;
                    if (go & lead) und_pend <= 1'b0;
                end
            end
        end
    end
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0] occ;
    logic pop, wr, ovr_q;
    assign pop = (occ != '0) & bus.rx_ready;
    assign wr = done_q & ((occ != (AW+1)'(DEPTH)) | pop);
    always_ff @(posedge clk) begin
        if (rst) begin
            mem <= '{default: '0};
            wp <= '0;
            rp <= '0;
            occ <= '0;
            ovr_q <= 1'b0;
        end else begin
            ovr_q <= done_q & ~wr;
            if (wr) begin
                mem[wp] <= rx_sh;
                wp <= wp == AW'(DEPTH - 1) ? '0 : wp + 1'b1;
            end
            if (pop) rp <= rp == AW'(DEPTH - 1) ? '0 : rp + 1'b1;
            occ <= occ + (AW+1)'(wr) - (AW+1)'(pop);
        end
    end
    assign bus.rx_data = mem[rp];
    assign bus.rx_valid = occ != '0;
    assign bus.tx_ready = ~hold_full;
    assign bus.miso = act & (LSB_FIRST != 0 ? tx_sh[0] : tx_sh[DW-1]);
    assign bus.miso_oe = act;
    assign bus.busy = act;
    assign bus.overrun = ovr_q;
    assign bus.underrun = underrun_q;
    assign bus.frame_err = frame_err_q;
endmodule
